// File: rtl/axi_axil_rd_adapter.sv
// AXI4 read burst to AXI-Lite single-beat read adapter.
// Splits one burst into arlen+1 lite reads and returns R beats with id/rlast.
module axi_axil_rd_adapter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 8,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
    input  logic [7:0]                 s_axi_arlen,
    input  logic [2:0]                 s_axi_arsize,
    input  logic [1:0]                 s_axi_arburst,
    input  logic                       s_axi_arlock,
    input  logic [3:0]                 s_axi_arcache,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rlast,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_STRB_WIDTH));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t                  state;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [7:0]              cnt_q;

    logic [2:0]              eff_size;
    logic [ADDR_WIDTH-1:0]   inc;
    logic [ADDR_WIDTH-1:0]   mask;
    logic [ADDR_WIDTH-1:0]   sum;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // lock and cache carry no meaning on the lite side
    logic unused_sigs;
    assign unused_sigs = ^{s_axi_arlock, s_axi_arcache};

    // next beat address; step clamped to the bus width
    always_comb begin
        eff_size  = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
        inc       = ADDR_WIDTH'(1) << eff_size;
        mask      = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << eff_size)
                    - ADDR_WIDTH'(1);
        sum       = addr_q + inc;
        next_addr = sum;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~mask) | (sum & mask);
            default: next_addr = sum;
        endcase
    end

    // burst FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            id_q           <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            cnt_q          <= '0;
            s_axi_arready  <= 1'b0;
            s_axi_rid      <= '0;
            s_axi_rdata    <= '0;
            s_axi_rresp    <= '0;
            s_axi_rlast    <= 1'b0;
            s_axi_rvalid   <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arprot  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        id_q           <= s_axi_arid;
                        addr_q         <= s_axi_araddr;
                        len_q          <= s_axi_arlen;
                        size_q         <= s_axi_arsize;
                        burst_q        <= s_axi_arburst;
                        cnt_q          <= '0;
                        m_axil_araddr  <= s_axi_araddr;
                        m_axil_arprot  <= s_axi_arprot;
                        m_axil_arvalid <= 1'b1;
                        s_axi_arready  <= 1'b0;
                        state          <= ADDR;
                    end else begin
                        s_axi_arready  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (m_axil_rvalid) begin
                        s_axi_rdata   <= m_axil_rdata;
                        s_axi_rresp   <= m_axil_rresp;
                        s_axi_rid     <= id_q;
                        s_axi_rlast   <= (cnt_q == len_q);
                        s_axi_rvalid  <= 1'b1;
                        m_axil_rready <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        if (s_axi_rlast) begin
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            cnt_q          <= cnt_q + 8'd1;
                            addr_q         <= next_addr;
                            m_axil_araddr  <= next_addr;
                            m_axil_arvalid <= 1'b1;
                            state          <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_axil_rd_adapter.sv
// Directed bench for axi_axil_rd_adapter.
// Acts as AXI master and AXI-Lite slave from one linear sequence.
module tb_axi_axil_rd_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;

    int total = 0;
    int bad   = 0;

    logic [31:0] ea [8];
    logic [1:0]  er [8];

    axi_axil_rd_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .s_axi_arid     (s_axi_arid),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_arlock   (s_axi_arlock),
        .s_axi_arcache  (s_axi_arcache),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rlast    (s_axi_rlast),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int b,
                                              input logic [31:0] a);
        return {8'hA5, 8'(b), a[15:0]};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arready"}, 64'(s_axi_arready), 0);
        chk({tag, "_rvalid"},  64'(s_axi_rvalid), 0);
        chk({tag, "_rlast"},   64'(s_axi_rlast), 0);
        chk({tag, "_rid"},     64'(s_axi_rid), 0);
        chk({tag, "_rdata"},   64'(s_axi_rdata), 0);
        chk({tag, "_rresp"},   64'(s_axi_rresp), 0);
        chk({tag, "_maraddr"}, 64'(m_axil_araddr), 0);
        chk({tag, "_marprot"}, 64'(m_axil_arprot), 0);
        chk({tag, "_marvalid"}, 64'(m_axil_arvalid), 0);
        chk({tag, "_mrready"}, 64'(m_axil_rready), 0);
    endtask

    // present an AR request and wait for its handshake
    task automatic issue(input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [2:0] prot);
        int n;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arprot  = prot;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", 64'(s_axi_arready), 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    // serve and collect len+1 beats; ea/er hold expected addr/resp
    task automatic run_burst(input logic [7:0] id, input int len,
                             input logic [2:0] prot, input int ard,
                             input int rd, input bit junk);
        int n;
        logic [31:0] d;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!m_axil_arvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("m_arvalid", 64'(m_axil_arvalid), 1);
            chk("m_araddr", 64'(m_axil_araddr), 64'(ea[b]));
            chk("m_arprot", 64'(m_axil_arprot), 64'(prot));
            for (int i = 0; i < ard; i++) begin
                m_axil_rvalid = junk;
                m_axil_rdata  = 32'hDEAD_BEEF;
                @(negedge clk);
                chk("ar_hold_v", 64'(m_axil_arvalid), 1);
                chk("ar_hold_a", 64'(m_axil_araddr), 64'(ea[b]));
                chk("ar_hold_rr", 64'(m_axil_rready), 0);
                chk("busy_arready", 64'(s_axi_arready), 0);
            end
            m_axil_rvalid  = 1'b0;
            m_axil_arready = 1'b1;
            @(negedge clk);
            m_axil_arready = 1'b0;
            chk("ar_done", 64'(m_axil_arvalid), 0);
            chk("rready_up", 64'(m_axil_rready), 1);
            d = beat_data(b, ea[b]);
            m_axil_rvalid = 1'b1;
            m_axil_rdata  = d;
            m_axil_rresp  = er[b];
            @(negedge clk);
            m_axil_rvalid = 1'b0;
            m_axil_rresp  = 2'b00;
            chk("rready_dn", 64'(m_axil_rready), 0);
            for (int i = 0; i <= rd; i++) begin
                chk("rvalid", 64'(s_axi_rvalid), 1);
                chk("rid", 64'(s_axi_rid), 64'(id));
                chk("rdata", 64'(s_axi_rdata), 64'(d));
                chk("rresp", 64'(s_axi_rresp), 64'(er[b]));
                chk("rlast", 64'(s_axi_rlast), 64'(b == len));
                if (i < rd) @(negedge clk);
            end
            s_axi_rready = 1'b1;
            @(negedge clk);
            s_axi_rready = 1'b0;
            chk("r_done", 64'(s_axi_rvalid), 0);
            if (b == len) chk("idle_arready", 64'(s_axi_arready), 1);
        end
    endtask

    initial begin
        rst = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = 1'b0;
        s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; m_axil_arready = 1'b0;
        m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst0");
        rst = 1'b1;
        #1;
        chk("pre_edge_arready", 64'(s_axi_arready), 0);
        @(negedge clk);
        chk("post_edge_arready", 64'(s_axi_arready), 1);

        // INCR 4 beats
        ea = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0};
        er = '{default: 2'b00};
        issue(8'h5A, 32'h1000, 8'd3, 3'd2, 2'b01, 3'd0);
        run_burst(8'h5A, 3, 3'd0, 0, 0, 1'b0);

        // WRAP 4 beats
        ea = '{32'h1008, 32'h100C, 32'h1000, 32'h1004, 0, 0, 0, 0};
        issue(8'h11, 32'h1008, 8'd3, 3'd2, 2'b10, 3'd5);
        run_burst(8'h11, 3, 3'd5, 0, 0, 1'b0);

        // FIXED 3 beats, SLVERR on beat 2
        ea = '{32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0};
        er = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        issue(8'h22, 32'h20, 8'd2, 3'd2, 2'b00, 3'd1);
        run_burst(8'h22, 2, 3'd1, 0, 0, 1'b0);
        er = '{default: 2'b00};

        // INCR across the top of the address space
        ea = '{32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0};
        issue(8'h33, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 3'd0);
        run_burst(8'h33, 1, 3'd0, 0, 0, 1'b0);

        // oversized arsize clamps to 4-byte steps
        ea = '{32'h200, 32'h204, 0, 0, 0, 0, 0, 0};
        issue(8'h44, 32'h200, 8'd1, 3'd3, 2'b01, 3'd0);
        run_burst(8'h44, 1, 3'd0, 0, 0, 1'b0);

        // backpressure on both sides, stray lite rvalid while in ADDR
        ea = '{32'h40, 32'h44, 0, 0, 0, 0, 0, 0};
        issue(8'h66, 32'h40, 8'd1, 3'd2, 2'b01, 3'd2);
        run_burst(8'h66, 1, 3'd2, 4, 3, 1'b1);
        ea = '{32'h80, 0, 0, 0, 0, 0, 0, 0};
        issue(8'h77, 32'h80, 8'd0, 3'd2, 2'b01, 3'd0);
        run_burst(8'h77, 0, 3'd0, 0, 0, 1'b0);

        // reset in the middle of a burst, while in DATA
        issue(8'h99, 32'h300, 8'd3, 3'd2, 2'b01, 3'd3);
        m_axil_arready = 1'b1;
        @(negedge clk);
        m_axil_arready = 1'b0;
        chk("mid_rready", 64'(m_axil_rready), 1);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'h1234_5678;
        @(negedge clk);
        m_axil_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_arready0", 64'(s_axi_arready), 0);
        @(negedge clk);
        chk("rel_arready1", 64'(s_axi_arready), 1);
        for (int i = 0; i < 4; i++) begin
            chk("no_stray_r", 64'(s_axi_rvalid), 0);
            chk("no_stray_ar", 64'(m_axil_arvalid), 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
